chess_layout_matrix: RTL and testbench

//  Holds the 8x8 chess board state as a packed 256-bit vector (64 squares x 4-bit piece code) for the LT24 renderer.

---
 rtl/chess_layout_matrix_pkg.sv | 32 +++
 rtl/chess_layout_matrix_key_debounce.sv | 44 ++++
 rtl/chess_layout_matrix.sv | 114 +++++++++++
 tb/tb_chess_layout_matrix.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/chess_layout_matrix_pkg.sv
// Shared board definitions: piece codes, board geometry and the opening layout.
package chess_pkg;

    localparam int unsigned SQUARE_WIDTH = 4;

    localparam logic [3:0] PIECE_EMPTY  = 4'd0;
    localparam logic [3:0] PIECE_PAWN   = 4'd1;
    localparam logic [3:0] PIECE_KNIGHT = 4'd2;
    localparam logic [3:0] PIECE_BISHOP = 4'd3;
    localparam logic [3:0] PIECE_ROOK   = 4'd4;
    localparam logic [3:0] PIECE_QUEEN  = 4'd5;
    localparam logic [3:0] PIECE_KING   = 4'd6;
    localparam logic [3:0] BLACK        = 4'h8;

    // Nibble i holds square i (row*8+col); the most significant nibble is square 63 (h1).
    // Row 0 (rank 8) is black: rook, knight, bishop, queen, king, bishop, knight, rook.
    localparam logic [255:0] INIT_LAYOUT =
        256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC;

    typedef enum logic [2:0] {
        MOVE_NONE,
        MOVE_LEFT,
        MOVE_RIGHT,
        MOVE_UP,
        MOVE_DOWN
    } moveDir_e;

    function automatic logic [5:0] sq_idx(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/chess_layout_matrix_key_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer with a change pulse.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic clock,
    input  logic resetApp_n,
    input  logic rawIn,
    output logic level,
    output logic toggle
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta;
    logic             syncOut;
    logic [CNT_W-1:0] stableCnt;

    // Synchronise the raw input and accept a new level only after it has differed for the full window.
    always_ff @(posedge clock or negedge resetApp_n) begin
        if (!resetApp_n) begin
            syncMeta  <= IDLE_LEVEL;
            syncOut   <= IDLE_LEVEL;
            level     <= IDLE_LEVEL;
            stableCnt <= '0;
            toggle    <= 1'b0;
        end else begin
            syncMeta <= rawIn;
            syncOut  <= syncMeta;
            toggle   <= 1'b0;
            if (syncOut == level) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                level     <= syncOut;
                stableCnt <= '0;
                toggle    <= 1'b1;
            end else begin
                stableCnt <= stableCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chess_layout_matrix.sv
// Board state, cursor and pick/place control driven by debounced keys and the lock switch.
module chess_layout_matrix
    import chess_pkg::*;
#(
    parameter int unsigned CHESS_SQUARES   = 64,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                                clock,
    input  logic                                resetApp_n,
    input  logic                                KeyLeft,
    input  logic                                KeyUp,
    input  logic                                KeyDown,
    input  logic                                KeyRight,
    input  logic                                LockSwitch,
    output logic [CHESS_SQUARES*SQUARE_WIDTH-1:0] Matrix,
    output logic [5:0]                          CursorIdx,
    output logic                                Holding,
    output logic [SQUARE_WIDTH-1:0]             HeldPiece
);

    logic [SQUARE_WIDTH-1:0] board [CHESS_SQUARES];

    logic leftLevel, leftToggle;
    logic upLevel, upToggle;
    logic downLevel, downToggle;
    logic rightLevel, rightToggle;
    logic lockLevel, lockToggle;

    logic pressLeft, pressUp, pressDown, pressRight;
    logic lockOn, lockOff;

    moveDir_e   moveDir;
    logic [5:0] nextCursor;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) uLeft (
        .clock(clock), .resetApp_n(resetApp_n), .rawIn(KeyLeft),
        .level(leftLevel), .toggle(leftToggle));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) uUp (
        .clock(clock), .resetApp_n(resetApp_n), .rawIn(KeyUp),
        .level(upLevel), .toggle(upToggle));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) uDown (
        .clock(clock), .resetApp_n(resetApp_n), .rawIn(KeyDown),
        .level(downLevel), .toggle(downToggle));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) uRight (
        .clock(clock), .resetApp_n(resetApp_n), .rawIn(KeyRight),
        .level(rightLevel), .toggle(rightToggle));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b0)) uLock (
        .clock(clock), .resetApp_n(resetApp_n), .rawIn(LockSwitch),
        .level(lockLevel), .toggle(lockToggle));

    // Keys are active-low: a press is a level change that lands on 0.
    assign pressLeft  = leftToggle  & ~leftLevel;
    assign pressUp    = upToggle    & ~upLevel;
    assign pressDown  = downToggle  & ~downLevel;
    assign pressRight = rightToggle & ~rightLevel;
    assign lockOn     = lockToggle  &  lockLevel;
    assign lockOff    = lockToggle  & ~lockLevel;

    // Decode a single key event into a move; simultaneous events cancel out.
    always_comb begin
        moveDir = MOVE_NONE;
        case ({pressLeft, pressRight, pressUp, pressDown})
            4'b1000: moveDir = MOVE_LEFT;
            4'b0100: moveDir = MOVE_RIGHT;
            4'b0010: moveDir = MOVE_UP;
            4'b0001: moveDir = MOVE_DOWN;
            default: moveDir = MOVE_NONE;
        endcase
    end

    // Saturating cursor step within the 8x8 grid.
    always_comb begin
        nextCursor = CursorIdx;
        case (moveDir)
            MOVE_LEFT:  if (CursorIdx[2:0] != 3'd0) nextCursor = sq_idx(CursorIdx[5:3], CursorIdx[2:0] - 3'd1);
            MOVE_RIGHT: if (CursorIdx[2:0] != 3'd7) nextCursor = sq_idx(CursorIdx[5:3], CursorIdx[2:0] + 3'd1);
            MOVE_UP:    if (CursorIdx[5:3] != 3'd0) nextCursor = sq_idx(CursorIdx[5:3] - 3'd1, CursorIdx[2:0]);
            MOVE_DOWN:  if (CursorIdx[5:3] != 3'd7) nextCursor = sq_idx(CursorIdx[5:3] + 3'd1, CursorIdx[2:0]);
            default:    nextCursor = CursorIdx;
        endcase
    end

    // Cursor, board and held-piece registers; pick/place uses the cursor before this cycle's move.
    always_ff @(posedge clock or negedge resetApp_n) begin
        if (!resetApp_n) begin
            for (int unsigned i = 0; i < CHESS_SQUARES; i++) begin
                board[i] <= INIT_LAYOUT[SQUARE_WIDTH*i +: SQUARE_WIDTH];
            end
            CursorIdx <= sq_idx(3'd6, 3'd4);
            Holding   <= 1'b0;
            HeldPiece <= PIECE_EMPTY;
        end else begin
            CursorIdx <= nextCursor;
            if (lockOn && !Holding && board[CursorIdx] != PIECE_EMPTY) begin
                HeldPiece        <= board[CursorIdx];
                board[CursorIdx] <= PIECE_EMPTY;
                Holding          <= 1'b1;
            end else if (lockOff && Holding) begin
                board[CursorIdx] <= HeldPiece;
                Holding          <= 1'b0;
                HeldPiece        <= PIECE_EMPTY;
            end
        end
    end

    // Pack the register array onto the renderer-facing vector.
    always_comb begin
        Matrix = '0;
        for (int unsigned i = 0; i < CHESS_SQUARES; i++) begin
            Matrix[SQUARE_WIDTH*i +: SQUARE_WIDTH] = board[i];
        end
    end

endmodule

// File: tb/tb_chess_layout_matrix.sv
// Directed and randomized checks of chess_layout_matrix against a square/row/column model.
module tb_chess_layout_matrix;

    logic         clock = 1'b0;
    logic         resetApp_n = 1'b0;
    logic         KeyLeft = 1'b1;
    logic         KeyUp = 1'b1;
    logic         KeyDown = 1'b1;
    logic         KeyRight = 1'b1;
    logic         LockSwitch = 1'b0;
    logic [255:0] Matrix;
    logic [5:0]   CursorIdx;
    logic         Holding;
    logic [3:0]   HeldPiece;

    int checks = 0;
    int errors = 0;

    // Reference model
    int mBoard [64];
    int mCursor;
    bit mHold;
    int mHeld;

    chess_layout_matrix #(.CHESS_SQUARES(64), .DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .resetApp_n(resetApp_n),
        .KeyLeft(KeyLeft), .KeyUp(KeyUp), .KeyDown(KeyDown), .KeyRight(KeyRight),
        .LockSwitch(LockSwitch), .Matrix(Matrix), .CursorIdx(CursorIdx),
        .Holding(Holding), .HeldPiece(HeldPiece));

    // Free-running clock
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] modelMatrix();
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) m[4*i +: 4] = 4'(mBoard[i]);
        return m;
    endfunction

    task automatic modelReset();
        int backRank [8];
        backRank = '{4, 2, 3, 5, 6, 3, 2, 4};
        for (int c = 0; c < 8; c++) begin
            mBoard[c]      = backRank[c] + 8;
            mBoard[8 + c]  = 9;
            mBoard[48 + c] = 1;
            mBoard[56 + c] = backRank[c];
            for (int r = 2; r < 6; r++) mBoard[r*8 + c] = 0;
        end
        mCursor = 52;
        mHold   = 1'b0;
        mHeld   = 0;
    endtask

    task automatic checkAll(input string tag);
        checkVal({tag, "_cursor"}, 256'(CursorIdx), 256'(mCursor));
        checkVal({tag, "_holding"}, 256'(Holding), 256'(mHold));
        checkVal({tag, "_held"}, 256'(HeldPiece), 256'(mHeld));
        checkVal({tag, "_matrix"}, Matrix, modelMatrix());
    endtask

    // Press the selected keys together for 10 clocks, then release and let things settle.
    task automatic pressKeys(input bit l, input bit r, input bit u, input bit d);
        int row, col;
        KeyLeft = ~l; KeyRight = ~r; KeyUp = ~u; KeyDown = ~d;
        tick(10);
        KeyLeft = 1'b1; KeyRight = 1'b1; KeyUp = 1'b1; KeyDown = 1'b1;
        tick(10);
        row = mCursor / 8;
        col = mCursor % 8;
        if (int'(l) + int'(r) + int'(u) + int'(d) == 1) begin
            if (l && col > 0) col--;
            if (r && col < 7) col++;
            if (u && row > 0) row--;
            if (d && row < 7) row++;
        end
        mCursor = row*8 + col;
    endtask

    task automatic setLock(input bit v);
        bit prev;
        prev = LockSwitch;
        LockSwitch = v;
        tick(10);
        if (!prev && v && !mHold && mBoard[mCursor] != 0) begin
            mHeld = mBoard[mCursor];
            mBoard[mCursor] = 0;
            mHold = 1'b1;
        end else if (prev && !v && mHold) begin
            mBoard[mCursor] = mHeld;
            mHold = 1'b0;
            mHeld = 0;
        end
    endtask

    task automatic glitchLeft();
        KeyLeft = 1'b0;
        tick(2);
        KeyLeft = 1'b1;
        tick(10);
    endtask

    initial begin
        logic [255:0] snap;
        int           act;

        // Step 1: reset state
        modelReset();
        tick(3);
        resetApp_n = 1'b1;
        tick(3);
        checkAll("reset");
        checkVal("reset_sq4", 256'(Matrix[19:16]), 256'd14);
        checkVal("reset_sq60", 256'(Matrix[243:240]), 256'd6);
        checkVal("reset_cursor52", 256'(CursorIdx), 256'd52);

        // Step 2: single move each way
        pressKeys(0, 1, 0, 0);
        checkVal("right_53", 256'(CursorIdx), 256'd53);
        checkAll("right");
        pressKeys(0, 0, 1, 0);
        checkVal("up_45", 256'(CursorIdx), 256'd45);

        // Step 3: edge saturation
        repeat (5) pressKeys(1, 0, 0, 0);
        pressKeys(0, 0, 0, 1);
        checkVal("at_48", 256'(CursorIdx), 256'd48);
        pressKeys(1, 0, 0, 0);
        checkVal("left_sat_48", 256'(CursorIdx), 256'd48);
        pressKeys(0, 0, 0, 1);
        checkVal("down_56", 256'(CursorIdx), 256'd56);
        pressKeys(0, 0, 0, 1);
        checkVal("down_sat_56", 256'(CursorIdx), 256'd56);
        checkAll("edges");

        // Step 4: glitch and simultaneous keys
        glitchLeft();
        checkVal("glitch_56", 256'(CursorIdx), 256'd56);
        pressKeys(1, 1, 0, 0);
        checkVal("simul_56", 256'(CursorIdx), 256'd56);
        checkAll("ignored");

        // Step 5: pick up pawn at 52, carry to 36
        repeat (4) pressKeys(0, 1, 0, 0);
        pressKeys(0, 0, 1, 0);
        checkVal("at_52", 256'(CursorIdx), 256'd52);
        setLock(1'b1);
        checkVal("pick_sq52", 256'(Matrix[211:208]), 256'd0);
        checkVal("pick_held", 256'(HeldPiece), 256'd1);
        checkVal("pick_holding", 256'(Holding), 256'd1);
        pressKeys(0, 0, 1, 0);
        pressKeys(0, 0, 1, 0);
        checkVal("carry_36", 256'(CursorIdx), 256'd36);
        setLock(1'b0);
        checkVal("place_sq36", 256'(Matrix[147:144]), 256'd1);
        checkVal("place_holding", 256'(Holding), 256'd0);
        checkAll("place");

        // Step 6: capture the black pawn on 12, then reset mid-hold
        setLock(1'b1);
        repeat (3) pressKeys(0, 0, 1, 0);
        setLock(1'b0);
        checkVal("capture_sq12", 256'(Matrix[51:48]), 256'd1);
        checkAll("capture");
        setLock(1'b1);
        checkAll("rehold");
        resetApp_n = 1'b0;
        LockSwitch = 1'b0;
        #2;
        modelReset();
        checkAll("reset_mid");
        tick(2);
        resetApp_n = 1'b1;
        tick(3);
        checkAll("after_reset");

        // Randomized phase: keys, lock toggles, double presses and glitches
        for (int n = 0; n < 120; n++) begin
            act = int'($urandom_range(0, 7));
            case (act)
                0: pressKeys(1, 0, 0, 0);
                1: pressKeys(0, 1, 0, 0);
                2: pressKeys(0, 0, 1, 0);
                3: pressKeys(0, 0, 0, 1);
                4, 5: setLock(~LockSwitch);
                6: pressKeys($urandom_range(0, 1) == 1, 1'b1, 1'b0, $urandom_range(0, 1) == 1);
                default: glitchLeft();
            endcase
            checkAll($sformatf("rand%0d", n));
        end

        snap = Matrix;
        checkVal("final_stable", snap, modelMatrix());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
